// File: rtl/neureka_binconv_pe_sched_pkg.sv
// neureka_binconv_pe_sched_pkg: shared types and defaults for the binconv PE scheduler.
package neureka_binconv_pe_sched_pkg;
  localparam int NEUREKA_BLOCK_SIZE = 32;
  localparam int QW_MAX_DEF = 8;
  localparam int KIN_CNT_W_DEF = 12;
  typedef enum logic [1:0] {
    MODE_3X3  = 2'd0,
    MODE_1X1  = 2'd1,
    MODE_DW   = 2'd2,
    MODE_RSVD = 2'd3
  } binconv_mode_e;
  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, DONE} sched_state_e;
  typedef struct packed {
    logic [2:0]               qw_bit;
    logic [KIN_CNT_W_DEF-1:0] kin_idx;
    logic                     last_bit;
    logic                     last_kin;
  } ctrl_pe_sched_t;
endpackage

// File: rtl/neureka_nested_counter.sv
// neureka_nested_counter: two-level wrap counter, inner loop nested inside outer loop.
module neureka_nested_counter #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 12
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear,
  input  logic             en,
  input  logic [IN_W-1:0]  inner_max,
  input  logic [OUT_W-1:0] outer_max,
  output logic [IN_W-1:0]  inner,
  output logic [OUT_W-1:0] outer,
  output logic             last_inner,
  output logic             last_outer
);
  assign last_inner = inner == inner_max;
  assign last_outer = outer == outer_max;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inner <= '0;
      outer <= '0;
    end else if (clear) begin
      inner <= '0;
      outer <= '0;
    end else if (en) begin
      inner <= last_inner ? '0 : inner + 1'b1;
      if (last_inner) outer <= last_outer ? '0 : outer + 1'b1;
    end
  end
endmodule

// File: rtl/neureka_binconv_pe_sched.sv
// neureka_binconv_pe_sched: walks weight bit-planes and channel tiles for one binconv PE,
// tracking in-flight results so done only fires after every step is consumed.
module neureka_binconv_pe_sched
  import neureka_binconv_pe_sched_pkg::*;
#(
  parameter int BLOCK_SIZE = NEUREKA_BLOCK_SIZE,
  parameter int QW_MAX     = QW_MAX_DEF,
  parameter int KIN_CNT_W  = KIN_CNT_W_DEF,
  parameter int MAX_OUTST  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  input  logic [3:0]            qw_i,
  input  logic [KIN_CNT_W-1:0]  n_kin_i,
  input  logic [BLOCK_SIZE-1:0] enable_col_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  issue_valid_o,
  input  logic                  issue_ready_i,
  output logic [2:0]            qw_bit_o,
  output logic [KIN_CNT_W-1:0]  kin_idx_o,
  output logic                  last_bit_o,
  output logic                  last_kin_o,
  output logic                  pe_clear_o,
  output logic                  pe_enable_o,
  output logic                  pe_dw_accum_o,
  output logic [BLOCK_SIZE-1:0] pe_enable_col_o,
  input  logic                  pres_valid_i,
  input  logic                  pres_ready_i
);
  localparam int OW = $clog2(MAX_OUTST + 1);
  sched_state_e state, state_nxt;
  binconv_mode_e mode_q;
  logic [3:0] qw_q;
  logic [KIN_CNT_W-1:0] n_kin_q, kin_idx;
  logic [BLOCK_SIZE-1:0] col_q;
  logic [OW-1:0] outst, outst_nxt;
  logic [2:0] bit_idx, inner_max;
  logic err_q, accept, illegal, fire, pres_fire, last_bit, last_kin;
  assign illegal = (qw_i == 4'd0) | (32'(qw_i) > QW_MAX) | (n_kin_i == '0) | (mode_i == 2'd3);
  assign accept = (state == IDLE) & start_i & ~clear_i;
  assign issue_valid_o = (state == ISSUE) & (32'(outst) < MAX_OUTST);
  assign fire = issue_valid_o & issue_ready_i;
  // a result handshake with nothing in flight is ignored so the counter cannot underflow
  assign pres_fire = pres_valid_i & pres_ready_i & (outst != '0);
  assign outst_nxt = outst + OW'(fire) - OW'(pres_fire);
  // 1x1 spreads bit-planes across columns, so each tile is a single step
  assign inner_max = (mode_q == MODE_1X1) ? 3'd0 : 3'(qw_q - 4'd1);
  neureka_nested_counter #(.IN_W(3), .OUT_W(KIN_CNT_W)) u_cnt (
    .clk_i,
    .rst_ni,
    .clear     (clear_i | (state == IDLE)),
    .en        (fire),
    .inner_max (inner_max),
    .outer_max (n_kin_q - 1'b1),
    .inner     (bit_idx),
    .outer     (kin_idx),
    .last_inner(last_bit),
    .last_outer(last_kin)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      mode_q  <= MODE_3X3;
      qw_q    <= '0;
      n_kin_q <= '0;
      col_q   <= '0;
      err_q   <= 1'b0;
      outst   <= '0;
    end else begin
      state <= state_nxt;
      outst <= clear_i ? '0 : outst_nxt;
      if (accept) begin
        mode_q  <= binconv_mode_e'(mode_i);
        qw_q    <= qw_i;
        n_kin_q <= n_kin_i;
        col_q   <= enable_col_i;
        err_q   <= illegal;
      end
    end
  end
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_i) state_nxt = illegal ? DONE : CLEAR;
      CLEAR:   state_nxt = ISSUE;
      ISSUE:   if (fire & last_bit & last_kin) state_nxt = DRAIN;
      DRAIN:   if (outst_nxt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear_i) state_nxt = IDLE;
  end
  assign busy_o          = state != IDLE;
  assign done_o          = state == DONE;
  assign err_o           = done_o & err_q;
  assign pe_clear_o      = state == CLEAR;
  assign pe_enable_o     = (state == ISSUE) | (state == DRAIN);
  assign pe_dw_accum_o   = busy_o & (mode_q == MODE_DW);
  assign pe_enable_col_o = busy_o ? col_q : '0;
  assign qw_bit_o        = bit_idx;
  assign kin_idx_o       = kin_idx;
  assign last_bit_o      = busy_o & last_bit;
  assign last_kin_o      = busy_o & last_kin;
endmodule

// File: tb/tb_neureka_binconv_pe_sched.sv
// tb_neureka_binconv_pe_sched: directed checks of the binconv PE scheduler with a
// downstream model that returns each result one cycle after its issue.
module tb_neureka_binconv_pe_sched;
  localparam int BS = 8;
  localparam int KW = 12;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic clear_i = 1'b0, start_i = 1'b0, issue_ready_i = 1'b1, pres_ready_i = 1'b1, pres_force = 1'b0;
  logic [1:0] mode_i = '0;
  logic [3:0] qw_i = '0;
  logic [KW-1:0] n_kin_i = '0;
  logic [BS-1:0] enable_col_i = '0;
  logic busy_o, done_o, err_o, issue_valid_o, last_bit_o, last_kin_o;
  logic pe_clear_o, pe_enable_o, pe_dw_accum_o, pres_valid_i;
  logic [2:0] qw_bit_o;
  logic [KW-1:0] kin_idx_o;
  logic [BS-1:0] pe_enable_col_o;
  int cyc = 0, pend = 0, t = 0;
  int n_cmp = 0, n_err = 0;
  int n_fire = 0, done_cnt = 0, done_cyc = 0, clr_cnt = 0, dw_bad = 0;
  logic done_err = 1'b0, dw_exp = 1'b0;
  logic [2:0] f_bit[64];
  logic [KW-1:0] f_kin[64];
  logic f_lb[64], f_lk[64];
  logic [BS-1:0] f_col[64];
  int f_cyc[64];

  neureka_binconv_pe_sched #(.BLOCK_SIZE(BS), .QW_MAX(8), .KIN_CNT_W(KW), .MAX_OUTST(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i), .mode_i(mode_i),
    .qw_i(qw_i), .n_kin_i(n_kin_i), .enable_col_i(enable_col_i), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .qw_bit_o(qw_bit_o), .kin_idx_o(kin_idx_o), .last_bit_o(last_bit_o), .last_kin_o(last_kin_o),
    .pe_clear_o(pe_clear_o), .pe_enable_o(pe_enable_o), .pe_dw_accum_o(pe_dw_accum_o),
    .pe_enable_col_o(pe_enable_col_o), .pres_valid_i(pres_valid_i), .pres_ready_i(pres_ready_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // downstream: each issued step produces a result one cycle later
  assign pres_valid_i = pres_force | (pend != 0);
  always @(posedge clk_i or negedge rst_ni)
    if (!rst_ni || clear_i) pend <= 0;
    else pend <= pend + int'(issue_valid_o && issue_ready_i) - int'(pres_valid_i && pres_ready_i && pend != 0);

  always @(negedge clk_i) begin
    if (issue_valid_o && issue_ready_i && n_fire < 64) begin
      f_bit[n_fire] = qw_bit_o;
      f_kin[n_fire] = kin_idx_o;
      f_lb[n_fire]  = last_bit_o;
      f_lk[n_fire]  = last_kin_o;
      f_col[n_fire] = pe_enable_col_o;
      f_cyc[n_fire] = cyc;
      n_fire++;
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = err_o;
    end
    if (pe_clear_o) clr_cnt++;
    if (busy_o && pe_dw_accum_o !== dw_exp) dw_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [1:0] m, input logic [3:0] q, input logic [KW-1:0] k, input logic [BS-1:0] c);
    @(negedge clk_i);
    n_fire = 0; done_cnt = 0; clr_cnt = 0; dw_bad = 0; done_cyc = 0;
    dw_exp = (m == 2'd2);
    mode_i = m; qw_i = q; n_kin_i = k; enable_col_i = c;
    start_i = 1'b1;
    t = cyc;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done_cnt == 0 && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    chk({tag, " done seen"}, done_cnt, 1);
    repeat (3) @(negedge clk_i);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    settle(3);
    chk("reset ctrl", {issue_valid_o, busy_o, done_o, err_o, pe_clear_o, pe_enable_o, pe_dw_accum_o,
                       last_bit_o, last_kin_o, qw_bit_o}, 0);
    chk("reset kin/col", {kin_idx_o, pe_enable_col_o}, 0);
    rst_ni = 1'b1;
    settle(1);
    chk("post-reset idle", busy_o, 0);

    // 3x3, qw=4, n_kin=2: 8 steps, done at t+11
    launch(2'd0, 4'd4, 12'd2, 8'hA5);
    wait_done("t1");
    chk("t1 fires", n_fire, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1 step%0d", i), {f_bit[i], f_kin[i], f_lb[i], f_lk[i]},
          {3'(i % 4), 12'(i / 4), i % 4 == 3, i >= 4});
      chk($sformatf("t1 cyc%0d", i), f_cyc[i] - t, 2 + i);
    end
    chk("t1 done cyc", done_cyc - t, 11);
    chk("t1 err", done_err, 0);
    chk("t1 clear count", clr_cnt, 1);
    chk("t1 col", f_col[0], 8'hA5);
    chk("t1 idle col", {busy_o, pe_enable_col_o}, 0);

    // 1x1, qw=8, n_kin=3: one step per tile
    launch(2'd1, 4'd8, 12'd3, 8'h0F);
    wait_done("t2");
    chk("t2 fires", n_fire, 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("t2 step%0d", i), {f_bit[i], f_kin[i], f_lb[i], f_lk[i]}, {3'd0, 12'(i), 1'b1, i == 2});
    chk("t2 done cyc", done_cyc - t, 6);
    chk("t2 dw off", dw_bad, 0);

    // depthwise, qw=2, n_kin=1, results held back for 5 cycles
    pres_ready_i = 1'b0;
    launch(2'd2, 4'd2, 12'd1, 8'hFF);
    while (cyc < t + 5) @(negedge clk_i);
    chk("t3 fires held", n_fire, 2);
    chk("t3 held ctrl", {issue_valid_o, busy_o, pe_enable_o, pe_dw_accum_o, done_cnt[0]}, 5'b01110);
    pres_ready_i = 1'b1;
    wait_done("t3");
    chk("t3 done cyc", done_cyc - t, 7);
    chk("t3 dw on", dw_bad, 0);
    chk("t3 bits", {f_bit[0], f_lb[0], f_bit[1], f_lb[1]}, {3'd0, 1'b0, 3'd1, 1'b1});

    // issue backpressure: step outputs must hold
    issue_ready_i = 1'b0;
    launch(2'd0, 4'd2, 12'd1, 8'h3C);
    while (cyc < t + 2) @(negedge clk_i);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t4 stall%0d", i), {issue_valid_o, qw_bit_o, kin_idx_o, last_bit_o, last_kin_o},
          {1'b1, 3'd0, 12'd0, 1'b0, 1'b1});
      if (i < 2) @(negedge clk_i);
    end
    issue_ready_i = 1'b1;
    wait_done("t4");
    chk("t4 done cyc", done_cyc - t, 7);
    chk("t4 fires", {n_fire[3:0], f_bit[1], f_lb[1]}, {4'd2, 3'd1, 1'b1});

    // illegal configs: done+err at t+1, no clear, no issue
    launch(2'd0, 4'd0, 12'd2, 8'h01);
    wait_done("t5a");
    chk("t5a qw0", {done_cyc - t, 7'(clr_cnt), 8'(n_fire), done_err, busy_o}, {32'd1, 7'd0, 8'd0, 1'b1, 1'b0});
    launch(2'd0, 4'd3, 12'd0, 8'h01);
    wait_done("t5b");
    chk("t5b nkin0", {done_cyc - t, 7'(clr_cnt), 8'(n_fire), done_err, busy_o}, {32'd1, 7'd0, 8'd0, 1'b1, 1'b0});
    launch(2'd3, 4'd2, 12'd1, 8'h01);
    wait_done("t5c");
    chk("t5c mode3", {done_cyc - t, done_err, 7'(clr_cnt)}, {32'd1, 1'b1, 7'd0});
    launch(2'd0, 4'd9, 12'd1, 8'h01);
    wait_done("t5d");
    chk("t5d qw9", {done_cyc - t, done_err, 7'(clr_cnt)}, {32'd1, 1'b1, 7'd0});

    // clear after 3 of 8 fires, then a full rerun
    launch(2'd0, 4'd4, 12'd2, 8'hFF);
    while (cyc < t + 4) @(negedge clk_i);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    chk("t6 cleared", {busy_o, issue_valid_o, pe_enable_o}, 0);
    chk("t6 fires", n_fire, 3);
    settle(4);
    chk("t6 no done", done_cnt, 0);
    launch(2'd0, 4'd4, 12'd2, 8'hFF);
    wait_done("t6r");
    chk("t6r fires", n_fire, 8);
    chk("t6r first", {f_bit[0], f_kin[0]}, 0);
    chk("t6r last", {f_bit[7], f_kin[7], f_lb[7], f_lk[7]}, {3'd3, 12'd1, 1'b1, 1'b1});
    chk("t6r done cyc", done_cyc - t, 11);

    // clear beats a simultaneous start
    @(negedge clk_i);
    start_i = 1'b1; clear_i = 1'b1; qw_i = 4'd2; n_kin_i = 12'd1; mode_i = 2'd0;
    @(negedge clk_i);
    start_i = 1'b0; clear_i = 1'b0;
    chk("t7 clear wins", {busy_o, pe_clear_o}, 0);

    // start during DRAIN ignored; fire+pres at outstanding=1 keeps one in flight
    launch(2'd0, 4'd2, 12'd1, 8'h11);
    while (cyc < t + 4) @(negedge clk_i);
    chk("t8 in drain", {busy_o, issue_valid_o, pe_enable_o}, 3'b101);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done("t8");
    settle(4);
    chk("t8 one done", done_cnt, 1);
    chk("t8 done cyc", done_cyc - t, 5);
    chk("t8 idle", {busy_o, 7'(clr_cnt)}, {1'b0, 7'd1});

    // stray result while idle must not disturb the next job
    @(negedge clk_i);
    pres_force = 1'b1;
    @(negedge clk_i);
    pres_force = 1'b0;
    launch(2'd0, 4'd1, 12'd2, 8'h80);
    wait_done("t9");
    chk("t9 done cyc", done_cyc - t, 5);
    chk("t9 fires", {n_fire[3:0], f_kin[1], f_lb[1], f_lk[1]}, {4'd2, 12'd1, 1'b1, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
